// File: rtl/encoder_8to3_req.sv
// ============================================================================
// Module  : encoder_8to3_req
// Brief   : Registered 8-to-3 request encoder with valid/accept handshake.
//           Define ROUND_ROBIN_EN for rotating priority (fixed otherwise).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_8to3_req #(
   parameter int PRIO_HIGH = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       E,
   input  logic [7:0] X,
   input  logic       A,
   input  logic       OVF_CLR,
   output logic [2:0] Z,
   output logic       V,
   output logic [7:0] P,
   output logic       OVF
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [2:0] c_top = (PRIO_HIGH != 0) ? 3'd7 : 3'd0;

   state_t     r_state;
   state_t     w_state_next;
   logic [2:0] w_start;
   logic [2:0] w_idx;
   logic [2:0] w_win;
   logic       w_found;
   logic       w_any;
   logic       w_load;
   logic [7:0] w_mask;
   logic [7:0] w_req;

`ifdef ROUND_ROBIN_EN
   logic [2:0] r_ptr;

   // Search resumes one step below the last grant, wrapping around.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= c_top;
      end else if (w_load) begin
         r_ptr <= (PRIO_HIGH != 0) ? (w_win - 3'd1) : (w_win + 3'd1);
      end
   end

   assign w_start = r_ptr;
`else
   assign w_start = c_top;
`endif

   always_comb begin
      w_win   = w_start;
      w_found = 1'b0;
      w_idx   = w_start;
      for (int i = 0; i < 8; i++) begin
         w_idx = (PRIO_HIGH != 0) ? (w_start - 3'(i)) : (w_start + 3'(i));
         if (!w_found && P[w_idx]) begin
            w_win   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   assign w_any  = |P;
   assign w_load = w_any && ((r_state == IDLE) || A);
   assign w_mask = w_load ? (8'd1 << w_win) : 8'd0;
   assign w_req  = X & {8{E}};
   assign V      = (r_state == HOLD);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_any) w_state_next = HOLD;
         HOLD:    if (A && !w_any) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // A re-request of the bit being loaded wins over its clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         P       <= 8'h00;
         Z       <= 3'd0;
         OVF     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         P       <= (P & ~w_mask) | w_req;
         OVF     <= (|(w_req & P & ~w_mask)) | (OVF & ~OVF_CLR);
         if (w_load) begin
            Z <= w_win;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_encoder_8to3_req.sv
// ============================================================================
// Module  : tb_encoder_8to3_req
// Brief   : Scoreboard bench for encoder_8to3_req (expected indices queued).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encoder_8to3_req;

   logic       clk;
   logic       reset_n;
   logic       E;
   logic [7:0] X;
   logic       A;
   logic       OVF_CLR;
   logic [2:0] Z;
   logic       V;
   logic [7:0] P;
   logic       OVF;

   int         n_checks;
   int         n_pass;
   logic [2:0] sb_q[$];

   encoder_8to3_req #(.PRIO_HIGH(1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .E       (E),
      .X       (X),
      .A       (A),
      .OVF_CLR (OVF_CLR),
      .Z       (Z),
      .V       (V),
      .P       (P),
      .OVF     (OVF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (sb_q.size() == 0 && !V) break;
         tick();
      end
      check({tag, "_q_empty"}, 32'(sb_q.size()), 32'd0);
      check({tag, "_v_low"}, 32'(V), 32'd0);
   endtask

   // Every accepted transfer must match the next queued index.
   always @(negedge clk) begin
      if (reset_n && V && A) begin
         if (sb_q.size() == 0) check("sb_extra_out", 32'(sb_q.size()), 32'd1);
         else check("sb_z", 32'(Z), 32'(sb_q.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      E        = 1'b0;
      X        = 8'h00;
      A        = 1'b0;
      OVF_CLR  = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      check("rst_p", 32'(P), 32'h00);
      check("rst_z", 32'(Z), 32'd0);
      check("rst_v", 32'(V), 32'd0);
      check("rst_ovf", 32'(OVF), 32'd0);

      // Single request
      A = 1'b1; E = 1'b1; X = 8'h08;
      sb_q.push_back(3'd3);
      tick();
      check("single_p", 32'(P), 32'h08);
      check("single_v0", 32'(V), 32'd0);
      E = 1'b0; X = 8'h00;
      tick();
      check("single_z", 32'(Z), 32'd3);
      check("single_v1", 32'(V), 32'd1);
      tick();
      check("single_v_fall", 32'(V), 32'd0);
      wait_drain("single");

      // Burst with backpressure
      A = 1'b0; E = 1'b1; X = 8'hA5;
      sb_q.push_back(3'd7); sb_q.push_back(3'd5);
      sb_q.push_back(3'd2); sb_q.push_back(3'd0);
      tick();
      E = 1'b0; X = 8'h00;
      tick();
      check("burst_z_first", 32'(Z), 32'd7);
      check("burst_p_left", 32'(P), 32'h25);
      tick(); tick();
      check("burst_z_held", 32'(Z), 32'd7);
      check("burst_v_held", 32'(V), 32'd1);
      A = 1'b1;
      wait_drain("burst");

      // Overflow: bit 4 re-requested while pending behind Z=6
      A = 1'b0; E = 1'b1; X = 8'h50;
      sb_q.push_back(3'd6); sb_q.push_back(3'd4);
      tick();
      E = 1'b0; X = 8'h00;
      tick();
      check("ovf_z6", 32'(Z), 32'd6);
      check("ovf_clear_before", 32'(OVF), 32'd0);
      E = 1'b1; X = 8'h10;
      tick();
      check("ovf_set", 32'(OVF), 32'd1);
      check("ovf_p", 32'(P), 32'h10);
      OVF_CLR = 1'b1;
      tick();
      check("ovf_set_wins_clr", 32'(OVF), 32'd1);
      E = 1'b0; X = 8'h00;
      tick();
      check("ovf_cleared", 32'(OVF), 32'd0);
      OVF_CLR = 1'b0;
      A = 1'b1;
      wait_drain("ovf");

      // Same-bit re-request during load
      A = 1'b1; E = 1'b1; X = 8'h04;
      sb_q.push_back(3'd2); sb_q.push_back(3'd2);
      tick();
      tick();
      check("same_p2", 32'(P), 32'h04);
      check("same_z", 32'(Z), 32'd2);
      check("same_ovf", 32'(OVF), 32'd0);
      E = 1'b0; X = 8'h00;
      tick();
      check("same_v_second", 32'(V), 32'd1);
      wait_drain("same");
      check("same_ovf_end", 32'(OVF), 32'd0);

      // Reset mid-operation
      A = 1'b0; E = 1'b1; X = 8'h24;
      tick();
      tick();
      check("mid_z5", 32'(Z), 32'd5);
      check("mid_ovf1", 32'(OVF), 32'd1);
      E = 1'b0; X = 8'h00;
      #3;
      reset_n = 1'b0;
      #1;
      check("mid_rst_p", 32'(P), 32'h00);
      check("mid_rst_z", 32'(Z), 32'd0);
      check("mid_rst_v", 32'(V), 32'd0);
      check("mid_rst_ovf", 32'(OVF), 32'd0);
      tick();
      reset_n = 1'b1;
      A = 1'b1;
      repeat (3) tick();
      check("mid_after_v", 32'(V), 32'd0);
      check("mid_after_p", 32'(P), 32'h00);

      // Both bits held every cycle: rotation vs fixed priority
`ifdef ROUND_ROBIN_EN
      sb_q.push_back(3'd7); sb_q.push_back(3'd0); sb_q.push_back(3'd7);
      sb_q.push_back(3'd0); sb_q.push_back(3'd7);
`else
      sb_q.push_back(3'd7); sb_q.push_back(3'd7); sb_q.push_back(3'd7);
      sb_q.push_back(3'd7); sb_q.push_back(3'd0);
`endif
      A = 1'b1; E = 1'b1; X = 8'h81;
      repeat (4) tick();
      E = 1'b0; X = 8'h00;
      wait_drain("rr");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
